// File: rtl/msg_intf_mc.sv
// msg_intf_mc - layer-engine message interface, multi-channel.
//
// Takes SAP execute requests (header + variable-length flit stream) from the
// receive message queue, assembles them into a command buffer, dispatches the
// command to one of C_NUM_CH engine channels and returns a completion carrying
// a status code to the send message queue.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   cmd_valid/type/length/
//   initiator/id              request header from the receive queue
//   cmd_data_valid/ready/data flit stream
//   cmd_done                  one-cycle pulse, pops the header from the queue
//   cpl_*                     completion towards the send queue
//   out_valid/accept          one-hot per-channel dispatch handshake
//   out_data/out_nflits       assembled command (flit 0 in LSBs), flit count
module msg_intf_mc #(
    parameter int unsigned C_FLIT_WIDTH    = 128,
    parameter int unsigned C_MAX_FLITS     = 8,
    parameter int unsigned C_NUM_CH        = 2,
    parameter logic [7:0]  C_TYPE_EXEC_REQ = 8'h10,
    parameter logic [7:0]  C_TYPE_EXEC_CPL = 8'h11
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_valid,
    input  logic [7:0]                            cmd_type,
    input  logic [9:0]                            cmd_length,
    input  logic [15:0]                           cmd_initiator,
    input  logic [9:0]                            cmd_id,
    input  logic                                  cmd_data_valid,
    output logic                                  cmd_data_ready,
    input  logic [C_FLIT_WIDTH-1:0]               cmd_data,
    output logic                                  cmd_done,
    output logic                                  cpl_valid,
    input  logic                                  cpl_ready,
    output logic [7:0]                            cpl_type,
    output logic [15:0]                           cpl_target,
    output logic [9:0]                            cpl_id,
    output logic [6:0]                            cpl_error,
    output logic [C_FLIT_WIDTH-1:0]               cpl_data,
    output logic [C_NUM_CH-1:0]                   out_valid,
    input  logic [C_NUM_CH-1:0]                   out_accept,
    output logic [C_MAX_FLITS*C_FLIT_WIDTH-1:0]   out_data,
    output logic [$clog2(C_MAX_FLITS+1)-1:0]      out_nflits
);

    localparam int unsigned BPF   = C_FLIT_WIDTH / 8;
    // ceil(1023 / 1) still fits: the drain path needs the unclamped count.
    localparam int unsigned NF_W  = 11;
    localparam int unsigned ONW   = $clog2(C_MAX_FLITS + 1);
    localparam int unsigned BUF_W = C_MAX_FLITS * C_FLIT_WIDTH;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_LOAD  = 5'b00010,
        S_DRAIN = 5'b00100,
        S_DISP  = 5'b01000,
        S_CPL   = 5'b10000
    } state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [NF_W-1:0]    nflits_q, nflits_d;
    logic [NF_W-1:0]    cnt_q, cnt_d;
    logic [15:0]        init_q, init_d;
    logic [9:0]         id_q, id_d;
    logic [6:0]         err_q, err_d;
    logic [7:0]         ch_q, ch_d;
    logic               cmd_done_q, cmd_done_d;

    logic [NF_W-1:0]    nflits_in;
    logic               type_bad, len_bad, hdr_take, flit_hs, last_flit, ch_bad;

    assign nflits_in = NF_W'((32'(cmd_length) + BPF - 1) / BPF);
    assign type_bad  = (cmd_type != C_TYPE_EXEC_REQ);
    assign len_bad   = (cmd_length == '0) || (nflits_in > NF_W'(C_MAX_FLITS));
    // The header stays visible while cmd_done is in flight; ignore it for
    // that one cycle so the same request is not taken twice.
    assign hdr_take  = (state_q == S_IDLE) && cmd_valid && !cmd_done_q;
    assign flit_hs   = cmd_data_valid && cmd_data_ready;
    assign last_flit = flit_hs && ((cnt_q + NF_W'(1)) == nflits_q);
    assign ch_bad    = ({1'b0, cmd_data[7:0]} >= 9'(C_NUM_CH));

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            nflits_q   <= '0;
            cnt_q      <= '0;
            init_q     <= '0;
            id_q       <= '0;
            err_q      <= '0;
            ch_q       <= '0;
            cmd_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            nflits_q   <= nflits_d;
            cnt_q      <= cnt_d;
            init_q     <= init_d;
            id_q       <= id_d;
            err_q      <= err_d;
            ch_q       <= ch_d;
            cmd_done_q <= cmd_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (hdr_take) state_d = (type_bad || len_bad) ? S_DRAIN : S_LOAD;
            S_LOAD:  if (last_flit) state_d = (err_d != '0) ? S_CPL : S_DISP;
            S_DRAIN: if ((cnt_q == nflits_q) || last_flit) state_d = S_CPL;
            S_DISP:  if (|(out_valid & out_accept)) state_d = S_CPL;
            S_CPL:   if (cpl_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        buf_d      = buf_q;
        nflits_d   = nflits_q;
        cnt_d      = cnt_q;
        init_d     = init_q;
        id_d       = id_q;
        err_d      = err_q;
        ch_d       = ch_q;
        cmd_done_d = (state_q == S_CPL) && cpl_ready;

        if (hdr_take) begin
            init_d   = cmd_initiator;
            id_d     = cmd_id;
            nflits_d = nflits_in;
            cnt_d    = '0;
            buf_d    = '0;
            ch_d     = '0;
            err_d    = type_bad ? 7'd1 : (len_bad ? 7'd2 : 7'd0);
        end

        // Drained flits only advance the counter; they never touch the buffer.
        if (flit_hs) begin
            cnt_d = cnt_q + NF_W'(1);
            if (state_q == S_LOAD) begin
                for (int unsigned i = 0; i < C_MAX_FLITS; i++) begin
                    if (cnt_q == NF_W'(i))
                        buf_d[i*C_FLIT_WIDTH +: C_FLIT_WIDTH] = cmd_data;
                end
                if (cnt_q == '0) begin
                    ch_d = cmd_data[7:0];
                    if (ch_bad) err_d = 7'd3;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        cmd_data_ready = (state_q == S_LOAD) ||
                         ((state_q == S_DRAIN) && (cnt_q != nflits_q));
        cpl_valid      = (state_q == S_CPL);
        cpl_type       = cpl_valid ? C_TYPE_EXEC_CPL : 8'h00;
        cpl_data       = '0;
        cpl_data[7:0]  = cnt_q[7:0];
        out_valid      = '0;
        for (int unsigned c = 0; c < C_NUM_CH; c++)
            out_valid[c] = (state_q == S_DISP) && (ch_q == 8'(c));
    end

    assign cmd_done   = cmd_done_q;
    assign cpl_target = init_q;
    assign cpl_id     = id_q;
    assign cpl_error  = err_q;
    assign out_data   = buf_q;
    assign out_nflits = nflits_q[ONW-1:0];

endmodule

// File: tb/tb_msg_intf_mc.sv
// tb_msg_intf_mc - self-checking bench for msg_intf_mc.
//
// Drives directed and randomized requests; expected values come from a
// request-level model (byte length -> flit count, error priority, one-hot
// channel, zero-padded buffer image) evaluated inside run_cmd.
module tb_msg_intf_mc;

    localparam int FW  = 128;
    localparam int MF  = 8;
    localparam int NCH = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic [7:0]           cmd_type = '0;
    logic [9:0]           cmd_length = '0;
    logic [15:0]          cmd_initiator = '0;
    logic [9:0]           cmd_id = '0;
    logic                 cmd_data_valid = 1'b0;
    logic                 cmd_data_ready;
    logic [FW-1:0]        cmd_data = '0;
    logic                 cmd_done;
    logic                 cpl_valid;
    logic                 cpl_ready = 1'b0;
    logic [7:0]           cpl_type;
    logic [15:0]          cpl_target;
    logic [9:0]           cpl_id;
    logic [6:0]           cpl_error;
    logic [FW-1:0]        cpl_data;
    logic [NCH-1:0]       out_valid;
    logic [NCH-1:0]       out_accept = '0;
    logic [MF*FW-1:0]     out_data;
    logic [3:0]           out_nflits;

    int total = 0;
    int bad   = 0;
    logic [FW-1:0] flits [64];

    msg_intf_mc dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_length(cmd_length),
        .cmd_initiator(cmd_initiator), .cmd_id(cmd_id),
        .cmd_data_valid(cmd_data_valid), .cmd_data_ready(cmd_data_ready),
        .cmd_data(cmd_data), .cmd_done(cmd_done),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_type(cpl_type),
        .cpl_target(cpl_target), .cpl_id(cpl_id), .cpl_error(cpl_error),
        .cpl_data(cpl_data),
        .out_valid(out_valid), .out_accept(out_accept),
        .out_data(out_data), .out_nflits(out_nflits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string pfx);
        chk({pfx, "_out_valid"}, out_valid, 0);
        chk({pfx, "_cpl_valid"}, cpl_valid, 0);
        chk({pfx, "_cmd_done"}, cmd_done, 0);
        chk({pfx, "_ready"}, cmd_data_ready, 0);
        chk({pfx, "_out_data_any"}, |out_data, 0);
        chk({pfx, "_out_nflits"}, out_nflits, 0);
        chk({pfx, "_cpl_type"}, cpl_type, 0);
        chk({pfx, "_cpl_error"}, cpl_error, 0);
        chk({pfx, "_cpl_data"}, cpl_data, 0);
        chk({pfx, "_cpl_target"}, cpl_target, 0);
        chk({pfx, "_cpl_id"}, cpl_id, 0);
    endtask

    // One request, entered and left at posedge+1 with the DUT idle.
    task automatic run_cmd(input logic [7:0] typ, input int len, input int ch,
                           input int gap, input int acc_hold, input int rdy_hold,
                           input bit rst_disp);
        int nfl, err, cnt, iter, first_rdy;
        bit seen, hs, early;
        logic [15:0]    ini;
        logic [9:0]     tid;
        logic [NCH-1:0] oh;
        logic [7:0]     ch8;

        // reference model of the request
        nfl = (len + 15) / 16;
        if (typ != 8'h10)              err = 1;
        else if (len == 0 || nfl > MF) err = 2;
        else if (ch >= NCH)            err = 3;
        else                           err = 0;
        oh = '0;
        if (err == 0) oh[ch] = 1'b1;
        ini = 16'($urandom);
        tid = 10'($urandom);
        ch8 = 8'(ch);
        for (int i = 0; i < 64; i++) flits[i] = {$urandom, $urandom, $urandom, $urandom};
        flits[0][7:0] = ch8;

        cmd_valid = 1'b1; cmd_type = typ; cmd_length = 10'(len);
        cmd_initiator = ini; cmd_id = tid;
        cnt = 0; iter = 0; first_rdy = -1; seen = 0; early = 0;
        while (!seen && iter < 400) begin
            cmd_data_valid = ($urandom_range(99) >= 32'(gap));
            cmd_data = flits[(cnt < 64) ? cnt : 63];
            @(negedge clk);
            if (cmd_data_ready && first_rdy < 0) first_rdy = iter;
            hs = cmd_data_valid && cmd_data_ready;
            @(posedge clk); #1;
            if (hs) cnt++;
            if (cmd_done) early = 1;
            if (out_valid != 0 || cpl_valid) seen = 1;
            iter++;
        end
        cmd_data_valid = 1'b0;
        chk("timeout", seen, 1);
        if (!seen) begin
            cmd_valid = 1'b0;
            return;
        end
        chk("consumed", cnt, nfl);
        if (nfl > 0) chk("rdy_latency", first_rdy, 1);
        chk("early_done", early, 0);

        if (err == 0) begin
            if (gap == 0) chk("last_to_valid", iter, nfl + 1);
            chk("out_valid", out_valid, oh);
            chk("out_nflits", out_nflits, nfl);
            chk("cpl_not_yet", cpl_valid, 0);
            for (int i = 0; i < MF; i++)
                chk($sformatf("out_flit%0d", i), out_data[i*FW +: FW], (i < nfl) ? flits[i] : '0);
            if (rst_disp) begin
                rst = 1'b0; cmd_valid = 1'b0; out_accept = '0;
                #1;
                chk_idle_outputs("disp_rst");
                @(posedge clk); #1;
                rst = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                chk("post_rst_done", cmd_done, 0);
                chk("post_rst_cpl", cpl_valid, 0);
                return;
            end
            out_accept = ~oh;  // other channels' accepts must be ignored
            repeat (acc_hold) begin @(posedge clk); #1; end
            if (acc_hold > 0) begin
                chk("hold_out_valid", out_valid, oh);
                chk("hold_flit0", out_data[FW-1:0], flits[0]);
                chk("hold_nflits", out_nflits, nfl);
                chk("hold_no_cpl", cpl_valid, 0);
            end
            out_accept = oh;
            @(posedge clk); #1;
            out_accept = '0;
            chk("acc_to_cpl", cpl_valid, 1);
            chk("out_valid_drop", out_valid, 0);
        end else begin
            chk("no_dispatch", out_valid, 0);
        end

        chk("cpl_valid", cpl_valid, 1);
        chk("cpl_type", cpl_type, 8'h11);
        chk("cpl_target", cpl_target, ini);
        chk("cpl_id", cpl_id, tid);
        chk("cpl_error", cpl_error, 7'(err));
        chk("cpl_data", cpl_data, FW'(nfl & 8'hff));
        repeat (rdy_hold) begin @(posedge clk); #1; end
        if (rdy_hold > 0) begin
            chk("hold_cpl_valid", cpl_valid, 1);
            chk("hold_cpl_error", cpl_error, 7'(err));
            chk("hold_cpl_id", cpl_id, tid);
            chk("hold_cpl_data", cpl_data, FW'(nfl & 8'hff));
        end
        chk("done_before_hs", cmd_done, 0);
        cpl_ready = 1'b1;
        @(posedge clk); #1;
        cpl_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("cmd_done_pulse", cmd_done, 1);
        chk("cpl_drop", cpl_valid, 0);
        @(posedge clk); #1;
        chk("cmd_done_single", cmd_done, 0);
        chk("idle_ready", cmd_data_ready, 0);
    endtask

    initial begin
        // reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // nominal: 48 bytes, channel 1, three flits
        run_cmd(8'h10, 48, 1, 0, 0, 0, 0);
        // full size, all buffer slots
        run_cmd(8'h10, 128, 0, 30, 2, 1, 0);
        // partial flit; upper slots must read 0 after the longer command
        run_cmd(8'h10, 17, 1, 0, 0, 0, 0);
        // unsupported type, drained
        run_cmd(8'h05, 32, 0, 0, 0, 0, 0);
        // zero length
        run_cmd(8'h10, 0, 0, 0, 0, 0, 0);
        // oversized: 10 flits drained
        run_cmd(8'h10, 160, 1, 20, 0, 0, 0);
        // bad channel
        run_cmd(8'h10, 48, 5, 0, 0, 0, 0);
        // single flit, back to back
        run_cmd(8'h10, 1, 0, 0, 0, 0, 0);
        // backpressure on every interface
        run_cmd(8'h10, 64, 0, 40, 20, 10, 0);
        // reset while dispatching, then a clean command
        run_cmd(8'h10, 48, 1, 0, 0, 0, 1);
        run_cmd(8'h10, 48, 1, 0, 0, 0, 0);

        // randomized mix
        for (int n = 0; n < 16; n++) begin
            logic [7:0] t;
            t = ($urandom_range(3) == 0) ? 8'h22 : 8'h10;
            run_cmd(t, $urandom_range(0, 200), $urandom_range(0, 3),
                    $urandom_range(0, 50), $urandom_range(0, 5),
                    $urandom_range(0, 5), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msg_intf_mc.md
# msg_intf_mc

Parametrised successor to the layer-engine message interface.
- Accepts SAP execute requests from the receive message queue as flits of variable length and assembles them into a command buffer.
- Dispatches the command to one of `C_NUM_CH` engine channels.
- Returns an execute-complete or error completion to the send message queue, carrying the status code on every request.
- Sits between the SAP queues and the layer engine control ports.

## Interface
Parameters:
- C_FLIT_WIDTH, 128, flit width in bits (multiple of 8)
- C_MAX_FLITS, 8, maximum flits per command
- C_NUM_CH, 2, number of engine output channels (≤ 256)
- C_TYPE_EXEC_REQ, 8'h10, accepted request type
- C_TYPE_EXEC_CPL, 8'h11, completion type

Ports (clock and reset first):
- clk  in  1  single clock
- rst  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  header fields valid
- cmd_type  in  8  request type
- cmd_length  in  10  payload length in bytes
- cmd_initiator  in  16  requester ID
- cmd_id  in  10  transaction ID
- cmd_data_valid  in  1  flit valid
- cmd_data_ready  out  1  flit accept
- cmd_data  in  C_FLIT_WIDTH  flit
- cmd_done  out  1  one-cycle pulse; pops header from queue
- cpl_valid  out  1  completion valid
- cpl_ready  in  1  completion accept
- cpl_type  out  8  completion type
- cpl_target  out  16  latched initiator
- cpl_id  out  10  latched ID
- cpl_error  out  7  status code
- cpl_data  out  C_FLIT_WIDTH  flit count in bits [7:0], zero elsewhere
- out_valid  out  C_NUM_CH  one-hot per-channel valid
- out_accept  in  C_NUM_CH  per-channel accept
- out_data  out  C_MAX_FLITS*C_FLIT_WIDTH  assembled command; flit 0 in LSBs
- out_nflits  out  clog2(C_MAX_FLITS+1)  flits valid in out_data

## Operation
Derived quantities:
- Bytes per flit: BPF = C_FLIT_WIDTH/8.
- Flit count: nflits = ceil(cmd_length/BPF), computed from the 10-bit length without truncation.
- Channel: taken from bits [7:0] of flit 0.

Error codes:
- 0: OK
- 1: unsupported type
- 2: bad length (0 bytes or nflits > C_MAX_FLITS)
- 3: channel ≥ C_NUM_CH

State machine (one-hot):
- IDLE:
  - Waits for cmd_valid.
  - On cmd_valid: latch initiator, id, nflits, and type check; clear the buffer to zero; zero the flit counter.
  - Go to LOAD if type is OK and length is OK.
  - Go to DRAIN with error 1 or 2 otherwise.
- LOAD:
  - cmd_data_ready=1.
  - Each handshake writes flit[counter] and increments the counter.
  - When flit 0 is written, check the channel; if bad, record error 3.
  - After the last flit: go to CPL if an error was recorded, else to DISPATCH.
- DRAIN:
  - cmd_data_ready=1.
  - Discards flits until ceil(cmd_length/BPF) flits have been consumed, using the full unclamped count; a 0-byte request consumes none.
  - Then goes to CPL.
- DISPATCH:
  - out_valid[ch]=1 and holds until out_accept[ch].
  - out_data and out_nflits stay stable while valid.
  - out_accept bits on other channels are ignored.
  - On accept, go to CPL with error 0.
- CPL:
  - cpl_valid=1 with cpl_type=C_TYPE_EXEC_CPL; fields stable until cpl_ready.
  - cpl_data[7:0] = flits consumed.
  - On handshake: pulse cmd_done and go to IDLE.

Error completions:
- Error 1: cpl_type is still C_TYPE_EXEC_CPL; cpl_error=1 distinguishes it.
- Error 2 with cmd_length > C_MAX_FLITS*BPF: flits are drained, never written to the buffer.

## Timing
- Reset: all outputs 0; state IDLE; buffer and counters 0.
- Mid-operation reset: immediate abort, with no completion and no cmd_done.
- Latency:
  - cmd_valid to first cmd_data_ready: 1 cycle.
  - Last flit to out_valid: 1 cycle.
  - out_accept to cpl_valid: 1 cycle.
  - cpl_ready to cmd_done: same cycle (registered pulse visible the following cycle); IDLE re-entered the following cycle.
- Throughput: minimum cycles per N-flit command = N + 4, given zero backpressure.
- Backpressure:
  - cmd_data_valid low stalls LOAD/DRAIN with no state loss.
  - out_accept and cpl_ready may stay low indefinitely.
- cmd_valid is sampled only in IDLE.
- Simultaneous cmd_data_valid and a state exit cannot occur, because ready is deasserted outside LOAD/DRAIN.

## Test plan
- Nominal request: type 8'h10, length 48, BPF 16, flit0[7:0]=1, three flits A/B/C.
  - out_valid=2'b10; out_nflits=3; out_data = {0…, C, B, A}.
  - After accept: cpl_error=0, cpl_data=3, cpl_id and cpl_target echo the header, and one cmd_done pulse.
- Full-size and partial-flit lengths:
  - length 128 → 8 flits, all buffer slots filled.
  - length 17 → 2 flits; upper slots read 0, including stale data from a prior longer command.
- Unsupported type: type 8'h05, length 32.
  - No out_valid; 2 flits drained; cpl_error=1; cpl_data=2.
- Bad length and bad channel:
  - length 0 → no flits consumed; cpl_error=2; cpl_data=0.
  - length 160 → 10 flits drained; cpl_error=2.
  - flit0[7:0]=5 with C_NUM_CH=2 → all flits consumed; cpl_error=3.
- Backpressure: random cmd_data_valid gaps; out_accept held low for 20 cycles; cpl_ready held low for 10 cycles.
  - Outputs stay stable while held; cmd_done pulses exactly once.
- Reset in DISPATCH with rst low for 1 cycle:
  - All outputs 0.
  - A following nominal command completes correctly.
